// File: rtl/optimsoc_sysconfig_pkg.sv
// Shared types and constants for the per-tile system configuration register block:
// the tile configuration struct, register offsets and the FLAGS word encoding.
package optimsoc_sysconfig_pkg;

  localparam int MAX_CTS = 64;

  typedef enum logic [1:0] {
    LMEM_PLAIN    = 2'd0,
    LMEM_EXTERNAL = 2'd1
  } lmem_style_t;

  typedef struct packed {
    logic [31:0]                NUMTILES;
    logic [31:0]                NUMCTS;
    logic [MAX_CTS-1:0][15:0]   CTLIST;
    logic [31:0]                CORES_PER_TILE;
    logic [31:0]                GMEM_SIZE;
    logic [31:0]                GMEM_TILE;
    logic [31:0]                LMEM_SIZE;
    lmem_style_t                LMEM_STYLE;
    logic                       NOC_ENABLE_VCHANNELS;
    logic                       ENABLE_BOOTROM;
    logic                       ENABLE_DM;
    logic                       ENABLE_PGAS;
    logic                       CORE_ENABLE_FPU;
    logic                       CORE_ENABLE_PERFCOUNTERS;
    logic                       NA_ENABLE_MPSIMPLE;
    logic                       NA_ENABLE_DMA;
    logic                       USE_DEBUG;
    logic [31:0]                NOC_FLIT_WIDTH;
    logic [31:0]                NOC_CHANNELS;
    logic [31:0]                DEBUG_NUM_MODS;
  } config_t;

  localparam logic [31:0] SIGNATURE = 32'h53C0_0002;

  // Byte offsets within the block
  localparam int REG_SIGNATURE      = 'h000;
  localparam int REG_TILEID         = 'h004;
  localparam int REG_NUMTILES       = 'h008;
  localparam int REG_NUMCTS         = 'h00C;
  localparam int REG_CORES_PER_TILE = 'h010;
  localparam int REG_GMEM_SIZE      = 'h014;
  localparam int REG_GMEM_TILE      = 'h018;
  localparam int REG_LMEM_SIZE      = 'h01C;
  localparam int REG_FLAGS          = 'h020;
  localparam int REG_NOC            = 'h024;
  localparam int REG_DEBUG_NUM_MODS = 'h028;
  localparam int REG_COREBASE       = 'h02C;
  localparam int REG_CYCLE_LO       = 'h030;
  localparam int REG_CYCLE_HI       = 'h034;
  localparam int REG_CHAN_EN        = 'h038;
  localparam int REG_LOCK           = 'h03C;
  localparam int REG_SCRATCH        = 'h040;
  localparam int REG_CTLIST         = 'h200;

  localparam int FLAG_NOC_VCHANNELS = 0;
  localparam int FLAG_BOOTROM       = 1;
  localparam int FLAG_DM            = 2;
  localparam int FLAG_PGAS          = 3;
  localparam int FLAG_FPU           = 4;
  localparam int FLAG_PERFCOUNTERS  = 5;
  localparam int FLAG_MPSIMPLE      = 6;
  localparam int FLAG_DMA           = 7;
  localparam int FLAG_USE_DEBUG     = 8;
  localparam int FLAG_LMEM_PLAIN    = 9;

  function automatic logic [31:0] sysconfig_flags(input config_t cfg);
    logic [31:0] f;
    f = '0;
    f[FLAG_NOC_VCHANNELS] = cfg.NOC_ENABLE_VCHANNELS;
    f[FLAG_BOOTROM]       = cfg.ENABLE_BOOTROM;
    f[FLAG_DM]            = cfg.ENABLE_DM;
    f[FLAG_PGAS]          = cfg.ENABLE_PGAS;
    f[FLAG_FPU]           = cfg.CORE_ENABLE_FPU;
    f[FLAG_PERFCOUNTERS]  = cfg.CORE_ENABLE_PERFCOUNTERS;
    f[FLAG_MPSIMPLE]      = cfg.NA_ENABLE_MPSIMPLE;
    f[FLAG_DMA]           = cfg.NA_ENABLE_DMA;
    f[FLAG_USE_DEBUG]     = cfg.USE_DEBUG;
    f[FLAG_LMEM_PLAIN]    = (cfg.LMEM_STYLE == LMEM_PLAIN);
    return f;
  endfunction

endpackage

// File: rtl/optimsoc_sysconfig_regs_cycle_counter.sv
// Free-running 64-bit cycle counter with a high-word shadow so software can
// read a consistent 64-bit value as LO followed by HI.
module sysconfig_cycle_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        latch,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  logic [63:0] count;
  logic [31:0] shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      shadow <= '0;
    end else begin
      count <= count + 64'd1;
      // Captured on the same edge that the LO word is sampled by the bus
      if (latch) shadow <= count[63:32];
    end
  end

  assign lo_o = count[31:0];
  assign hi_o = shadow;

endmodule

// File: rtl/optimsoc_sysconfig_regs.sv
// Wishbone slave exposing the tile's static configuration plus a cycle counter,
// NoC channel enables, scratch registers and a sticky write lock.
module optimsoc_sysconfig_regs
  import optimsoc_sysconfig_pkg::*;
#(
  parameter config_t CONFIG      = '0,
  parameter int      TILEID      = 0,
  parameter int      COREBASE    = 0,
  parameter int      NUM_SCRATCH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [15:0]                    wb_adr_i,
  input  logic [31:0]                    wb_dat_i,
  input  logic [3:0]                     wb_sel_i,
  input  logic                           wb_we_i,
  input  logic                           wb_cyc_i,
  input  logic                           wb_stb_i,
  output logic [31:0]                    wb_dat_o,
  output logic                           wb_ack_o,
  output logic                           wb_err_o,
  output logic [CONFIG.NOC_CHANNELS-1:0] noc_chan_en_o
);

  // Handshake: a request is taken on a rising edge where cyc & stb are high and
  // no response is in flight; exactly one of ack/err follows for one cycle.

  localparam int NCH = int'(CONFIG.NOC_CHANNELS);
  localparam int SW  = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

  logic [NCH-1:0] chan_en;
  logic           lock;
  logic [31:0]    scratch [NUM_SCRATCH];
  logic [31:0]    cyc_lo, cyc_hi;

  int             addr;
  logic [31:0]    rd_data;
  logic           mapped, writable;
  logic           is_chan, is_lock, is_scratch, is_cyc_lo;
  logic [SW-1:0]  sidx;
  logic [5:0]     cidx;
  logic [31:0]    scratch_wdata;
  logic           busy, hit, ok, commit;

  logic           unused_adr;
  assign unused_adr = ^wb_adr_i[1:0];

  always_comb begin
    addr       = int'({wb_adr_i[15:2], 2'b00});
    rd_data    = '0;
    mapped     = 1'b0;
    writable   = 1'b0;
    is_chan    = 1'b0;
    is_lock    = 1'b0;
    is_scratch = 1'b0;
    is_cyc_lo  = 1'b0;
    sidx       = '0;
    cidx       = '0;
    if (addr < REG_SCRATCH) begin
      mapped = 1'b1;
      case (addr)
        REG_SIGNATURE:      rd_data = SIGNATURE;
        REG_TILEID:         rd_data = 32'(TILEID);
        REG_NUMTILES:       rd_data = CONFIG.NUMTILES;
        REG_NUMCTS:         rd_data = CONFIG.NUMCTS;
        REG_CORES_PER_TILE: rd_data = CONFIG.CORES_PER_TILE;
        REG_GMEM_SIZE:      rd_data = CONFIG.GMEM_SIZE;
        REG_GMEM_TILE:      rd_data = CONFIG.GMEM_TILE;
        REG_LMEM_SIZE:      rd_data = CONFIG.LMEM_SIZE;
        REG_FLAGS:          rd_data = sysconfig_flags(CONFIG);
        REG_NOC:            rd_data = {CONFIG.NOC_FLIT_WIDTH[15:0], CONFIG.NOC_CHANNELS[15:0]};
        REG_DEBUG_NUM_MODS: rd_data = CONFIG.DEBUG_NUM_MODS;
        REG_COREBASE:       rd_data = 32'(COREBASE);
        REG_CYCLE_LO: begin
          rd_data   = cyc_lo;
          is_cyc_lo = 1'b1;
        end
        REG_CYCLE_HI:       rd_data = cyc_hi;
        REG_CHAN_EN: begin
          rd_data  = 32'(chan_en);
          writable = 1'b1;
          is_chan  = 1'b1;
        end
        REG_LOCK: begin
          rd_data  = {31'b0, lock};
          writable = 1'b1;
          is_lock  = 1'b1;
        end
        default:            mapped = 1'b0;
      endcase
    end else if (addr < REG_SCRATCH + 4 * NUM_SCRATCH) begin
      sidx       = SW'((addr - REG_SCRATCH) >> 2);
      mapped     = 1'b1;
      writable   = 1'b1;
      is_scratch = 1'b1;
      rd_data    = scratch[sidx];
    end else if (addr >= REG_CTLIST &&
                 ((addr - REG_CTLIST) >> 2) < int'(CONFIG.NUMCTS) &&
                 ((addr - REG_CTLIST) >> 2) < MAX_CTS) begin
      cidx    = 6'((addr - REG_CTLIST) >> 2);
      mapped  = 1'b1;
      rd_data = {16'h0, CONFIG.CTLIST[cidx]};
    end
  end

  always_comb begin
    scratch_wdata = scratch[sidx];
    for (int b = 0; b < 4; b++) begin
      if (wb_sel_i[b]) scratch_wdata[8*b +: 8] = wb_dat_i[8*b +: 8];
    end
  end

  assign busy = wb_ack_o | wb_err_o;
  assign hit  = wb_cyc_i & wb_stb_i & ~busy;

  // Locked writes to CHAN_EN/SCRATCH are refused; LOCK itself always acks
  always_comb begin
    ok = 1'b0;
    if (mapped) begin
      if (!wb_we_i)                              ok = 1'b1;
      else if (!writable)                        ok = 1'b0;
      else if ((is_chan || is_scratch) && lock)  ok = 1'b0;
      else                                       ok = 1'b1;
    end
  end

  assign commit = hit & wb_we_i & ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      chan_en  <= '1;
      lock     <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      wb_ack_o <= hit & ok;
      wb_err_o <= hit & ~ok;
      wb_dat_o <= (hit && ok && !wb_we_i) ? rd_data : 32'h0;
      if (commit && is_chan && wb_sel_i[0]) chan_en <= wb_dat_i[NCH-1:0];
      if (commit && is_lock && wb_sel_i[0] && wb_dat_i[0]) lock <= 1'b1;
      if (commit && is_scratch) scratch[sidx] <= scratch_wdata;
    end
  end

  assign noc_chan_en_o = chan_en;

  sysconfig_cycle_counter u_cycle (
    .clk   (clk),
    .rst   (rst),
    .latch (hit & ~wb_we_i & is_cyc_lo),
    .lo_o  (cyc_lo),
    .hi_o  (cyc_hi)
  );

endmodule
